// File: rtl/seg_enc_pkg.sv
// Shared constants for the segment pattern encoder: digit segment patterns, report codes,
// bus widths and the report FSM state type.
package seg_enc_pkg;

    localparam int unsigned SegW  = 15;
    localparam int unsigned CodeW = 4;

    localparam logic [SegW-1:0] SEG_DIGIT_0 = 15'h0C3F;
    localparam logic [SegW-1:0] SEG_DIGIT_1 = 15'h0406;
    localparam logic [SegW-1:0] SEG_DIGIT_2 = 15'h00DB;
    localparam logic [SegW-1:0] SEG_DIGIT_3 = 15'h00CF;
    localparam logic [SegW-1:0] SEG_DIGIT_4 = 15'h00E6;
    localparam logic [SegW-1:0] SEG_DIGIT_5 = 15'h00ED;
    localparam logic [SegW-1:0] SEG_DIGIT_6 = 15'h00FD;
    localparam logic [SegW-1:0] SEG_DIGIT_7 = 15'h1401;
    localparam logic [SegW-1:0] SEG_DIGIT_8 = 15'h00FF;
    localparam logic [SegW-1:0] SEG_DIGIT_9 = 15'h00EF;
    localparam logic [SegW-1:0] SEG_BLANK   = 15'h0000;

    localparam logic [CodeW-1:0] CODE_INVALID = 4'hE;
    localparam logic [CodeW-1:0] CODE_BLANK   = 4'hF;

    typedef enum logic {
        StIdle,
        StHold
    } seg_enc_state_e;

endpackage

// File: rtl/segment_pattern_encoder_if.sv
// Monitored segment bus plus the report handshake between encoder (slave) and consumer
// (master).
interface segment_pattern_encoder_if;
    import seg_enc_pkg::*;

    logic [SegW-1:0]  segment_in;
    logic [CodeW-1:0] code_out;
    logic             code_error;
    logic             code_valid;
    logic             code_ready;
    logic             overrun;
    logic             overrun_clr;

    modport slave (
        input  segment_in, code_ready, overrun_clr,
        output code_out, code_error, code_valid, overrun
    );

    modport master (
        output segment_in, code_ready, overrun_clr,
        input  code_out, code_error, code_valid, overrun
    );

endinterface

// File: rtl/seg_pattern_lookup.sv
// Combinational segment pattern to digit code decode; exact match on all 15 bits.
// SEG_ENC_BLANK_EN makes the all-off pattern a valid blank code instead of an error.
module seg_pattern_lookup
    import seg_enc_pkg::*;
(
    input  logic [SegW-1:0]  i_pattern,
    output logic [CodeW-1:0] o_code,
    output logic             o_error
);

    always_comb begin
        o_code  = CODE_INVALID;
        o_error = 1'b1;
        case (i_pattern)
            SEG_DIGIT_0: begin o_code = 4'd0; o_error = 1'b0; end
            SEG_DIGIT_1: begin o_code = 4'd1; o_error = 1'b0; end
            SEG_DIGIT_2: begin o_code = 4'd2; o_error = 1'b0; end
            SEG_DIGIT_3: begin o_code = 4'd3; o_error = 1'b0; end
            SEG_DIGIT_4: begin o_code = 4'd4; o_error = 1'b0; end
            SEG_DIGIT_5: begin o_code = 4'd5; o_error = 1'b0; end
            SEG_DIGIT_6: begin o_code = 4'd6; o_error = 1'b0; end
            SEG_DIGIT_7: begin o_code = 4'd7; o_error = 1'b0; end
            SEG_DIGIT_8: begin o_code = 4'd8; o_error = 1'b0; end
            SEG_DIGIT_9: begin o_code = 4'd9; o_error = 1'b0; end
`ifdef SEG_ENC_BLANK_EN
            SEG_BLANK:   begin o_code = CODE_BLANK; o_error = 1'b0; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/segment_pattern_encoder.sv
// Display readback monitor: reports a segment pattern once stable for STABLE_CYCLES samples.
// Optional SEG_ENC_BLANK_EN (in seg_pattern_lookup) reports the all-off bus as blank.
module segment_pattern_encoder
    import seg_enc_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    segment_pattern_encoder_if.slave bus
);

    localparam int unsigned     CntW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

    logic [SegW-1:0]  r_seg;
    logic [CntW-1:0]  r_cnt;
    logic             r_armed;
    logic [SegW-1:0]  r_last;
    logic             r_last_vld;
    seg_enc_state_e   r_state;
    logic [CodeW-1:0] r_code;
    logic             r_error;
    logic             r_valid;
    logic             r_overrun;

    logic [CntW-1:0]  w_cnt_nxt;
    logic             w_event;
    logic             w_drop;
    logic [CodeW-1:0] w_code;
    logic             w_error;

    seg_pattern_lookup u_lookup (
        .i_pattern (r_seg),
        .o_code    (w_code),
        .o_error   (w_error)
    );

    always_comb begin
        w_cnt_nxt = '0;
        if (bus.segment_in == r_seg) begin
            w_cnt_nxt = (r_cnt == CntMax) ? CntMax : r_cnt + CntW'(1);
        end
    end

    // r_armed makes the event one-shot per stable pattern, even when the report was dropped.
    assign w_event = (r_cnt == CntMax) && r_armed && (!r_last_vld || (r_seg != r_last));
    assign w_drop  = (r_state == StHold) && w_event && !bus.code_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg      <= '0;
            r_cnt      <= '0;
            r_armed    <= 1'b1;
            r_last     <= '0;
            r_last_vld <= 1'b0;
            r_state    <= StIdle;
            r_code     <= '0;
            r_error    <= 1'b0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_seg <= bus.segment_in;
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == '0) begin
                r_armed <= 1'b1;
            end else if (w_event) begin
                r_armed <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.overrun_clr) begin
                r_overrun <= 1'b0;
            end
            case (r_state)
                StIdle: begin
                    if (w_event) begin
                        r_code     <= w_code;
                        r_error    <= w_error;
                        r_valid    <= 1'b1;
                        r_last     <= r_seg;
                        r_last_vld <= 1'b1;
                        r_state    <= StHold;
                    end
                end
                StHold: begin
                    // Accept and a new event together: swap in the new report, stay in hold.
                    if (bus.code_ready) begin
                        if (w_event) begin
                            r_code     <= w_code;
                            r_error    <= w_error;
                            r_last     <= r_seg;
                            r_last_vld <= 1'b1;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.code_out   = r_code;
    assign bus.code_error = r_error;
    assign bus.code_valid = r_valid;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_segment_pattern_encoder.sv
// Self-checking bench for segment_pattern_encoder: lookup table sweep, latency, glitch,
// overrun and reset corners, with a scoreboard of accepted reports.
module tb_segment_pattern_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    segment_pattern_encoder_if b ();
    segment_pattern_encoder_if b1 ();

    segment_pattern_encoder #(.STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    segment_pattern_encoder #(.STABLE_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    typedef struct packed {
        logic [3:0] code;
        logic       err;
    } exp_t;

    typedef struct {
        logic [14:0] seg;
        logic [3:0]  code;
        logic        err;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check(name, sb.size(), 0);
    endtask

    // Scoreboard: every accepted report must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && b.code_valid && b.code_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_report", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_code", b.code_out, e.code);
                check("sb_err", b.code_error, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int vcount;
        tbl[0]  = '{15'h0C3F, 4'd0, 1'b0};
        tbl[1]  = '{15'h0406, 4'd1, 1'b0};
        tbl[2]  = '{15'h00DB, 4'd2, 1'b0};
        tbl[3]  = '{15'h00CF, 4'd3, 1'b0};
        tbl[4]  = '{15'h00E6, 4'd4, 1'b0};
        tbl[5]  = '{15'h00ED, 4'd5, 1'b0};
        tbl[6]  = '{15'h00FD, 4'd6, 1'b0};
        tbl[7]  = '{15'h1401, 4'd7, 1'b0};
        tbl[8]  = '{15'h00FF, 4'd8, 1'b0};
        tbl[9]  = '{15'h00EF, 4'd9, 1'b0};
        tbl[10] = '{15'h1234, 4'hE, 1'b1};
`ifdef SEG_ENC_BLANK_EN
        tbl[11] = '{15'h0000, 4'hF, 1'b0};
`else
        tbl[11] = '{15'h0000, 4'hE, 1'b1};
`endif

        b.segment_in   = '0;
        b.code_ready   = 1'b1;
        b.overrun_clr  = 1'b0;
        b1.segment_in  = '0;
        b1.code_ready  = 1'b1;
        b1.overrun_clr = 1'b0;
        tick(3);
        check("rst_code", b.code_out, 0);
        check("rst_err", b.code_error, 0);
        check("rst_valid", b.code_valid, 0);
        check("rst_ovr", b.overrun, 0);

        // Latency: pattern sampled at edge k, report visible after edge k+5, single pulse.
        b.segment_in = 15'h00DB;
        sb.push_back('{4'd2, 1'b0});
        rst_n = 1'b1;
        tick(5);
        check("lat_early_valid", b.code_valid, 0);
        tick();
        check("lat_valid", b.code_valid, 1);
        check("lat_code", b.code_out, 2);
        check("lat_err", b.code_error, 0);
        tick();
        check("lat_pulse", b.code_valid, 0);
        drain("lat_drain", 4);

        foreach (tbl[i]) begin
            b.segment_in = tbl[i].seg;
            sb.push_back('{tbl[i].code, tbl[i].err});
            drain("tbl_drain", 12);
            tick();
        end

        // Short transient then stable: one report; later glitch back to same pattern: none.
        b.segment_in = 15'h00CF;
        tick(2);
        b.segment_in = 15'h00DB;
        sb.push_back('{4'd2, 1'b0});
        drain("glitch_first", 12);
        tick(2);
        b.segment_in = 15'h00FF;
        tick();
        b.segment_in = 15'h00DB;
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (b.code_valid) vcount++;
        end
        check("glitch_no_repeat", vcount, 0);

        // Overrun with consumer stalled.
        b.code_ready = 1'b0;
        b.segment_in = 15'h0406;
        tick(6);
        check("hold_valid", b.code_valid, 1);
        check("hold_code", b.code_out, 1);
        check("hold_ovr0", b.overrun, 0);
        b.segment_in = 15'h1401;
        tick(6);
        check("drop_code", b.code_out, 1);
        check("drop_valid", b.code_valid, 1);
        check("drop_ovr", b.overrun, 1);
        b.overrun_clr = 1'b1;
        tick();
        b.overrun_clr = 1'b0;
        check("ovr_clr", b.overrun, 0);
        tick(2);
        check("ovr_no_reset", b.overrun, 0);
        b.segment_in = 15'h00FF;
        tick();
        b.segment_in = 15'h1401;
        tick(5);
        sb.push_back('{4'd1, 1'b0});
        sb.push_back('{4'd7, 1'b0});
        b.code_ready = 1'b1;
        tick();
        check("swap_valid", b.code_valid, 1);
        check("swap_code", b.code_out, 7);
        check("swap_ovr", b.overrun, 0);
        drain("swap_drain", 4);
        tick();
        check("swap_idle", b.code_valid, 0);

        // Clear and drop in the same cycle: overrun stays set.
        b.code_ready = 1'b0;
        b.segment_in = 15'h00ED;
        tick(6);
        check("cw_hold_code", b.code_out, 5);
        b.segment_in = 15'h00FD;
        tick(5);
        b.overrun_clr = 1'b1;
        tick();
        b.overrun_clr = 1'b0;
        check("cw_set_wins", b.overrun, 1);
        b.overrun_clr = 1'b1;
        tick();
        b.overrun_clr = 1'b0;
        check("cw_cleared", b.overrun, 0);
        sb.push_back('{4'd5, 1'b0});
        b.code_ready = 1'b1;
        drain("cw_drain", 4);

        // Reset while a report is pending, then report again after release.
        b.code_ready = 1'b0;
        b.segment_in = 15'h00FF;
        tick(6);
        check("mid_hold_code", b.code_out, 8);
        rst_n = 1'b0;
        #1;
        check("mid_rst_code", b.code_out, 0);
        check("mid_rst_valid", b.code_valid, 0);
        check("mid_rst_err", b.code_error, 0);
        tick(2);
        b.segment_in = 15'h00DB;
        b.code_ready = 1'b1;
        sb.push_back('{4'd2, 1'b0});
        rst_n = 1'b1;
        drain("rst_again", 12);

        // Single-cycle stability build.
        tick(3);
        b1.segment_in = 15'h0C3F;
        tick();
        check("s1_k", b1.code_valid, 0);
        tick();
        check("s1_k1", b1.code_valid, 0);
        tick();
        check("s1_valid", b1.code_valid, 1);
        check("s1_code", b1.code_out, 0);
        check("s1_err", b1.code_error, 0);

        tick(3);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
